// File: rtl/rif_regfile.sv
// rif_regfile: RIF-side register bank with ID, scratch, control, down-counting timer and W1C irq.
// Optional feature: define RIF_REGFILE_LOCK_EN for a sticky CTRL[31] LOCK that blocks config writes.
module rif_regfile #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IRQ_NUM     = 7,
    parameter int unsigned TIMER_WIDTH = 32,
    parameter logic [31:0] ID_VALUE    = 32'hA11C_0001
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] rif_addr,
    output logic                  rif_addr_valid,
    input  logic                  rif_wr_req,
    input  logic                  rif_rd_req,
    input  logic [3:0]            rif_wstrb,
    input  logic [DATA_WIDTH-1:0] rif_wdata,
    output logic [DATA_WIDTH-1:0] rif_rdata,
    input  logic [IRQ_NUM-1:0]    irq_src,
    output logic                  irq
);

    localparam logic [2:0] RegId     = 3'd0;
    localparam logic [2:0] RegScr    = 3'd1;
    localparam logic [2:0] RegCtrl   = 3'd2;
    localparam logic [2:0] RegStatus = 3'd3;
    localparam logic [2:0] RegMask   = 3'd4;
    localparam logic [2:0] RegLoad   = 3'd5;
    localparam logic [2:0] RegValue  = 3'd6;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]            scratch_q, scratch_d;
    logic                   en_q, en_d;
    logic                   ar_q, ar_d;
    logic [IRQ_NUM:0]       status_q, status_d;
    logic [IRQ_NUM:0]       mask_q, mask_d;
    logic [TIMER_WIDTH-1:0] load_q, load_d;
    logic [TIMER_WIDTH-1:0] value_q, value_d;
    logic [IRQ_NUM-1:0]     irq_src_q;
    logic                   irq_q;

    logic [2:0]  word;
    logic        decoded;
    logic        hit;
    logic        wr_scr, wr_ctrl, wr_status, wr_mask, wr_load;
    logic        expire;
    logic [31:0] ctrl_rd, status_rd, mask_rd, load_rd, value_rd;
    logic [31:0] ctrl_new, mask_new, load_new, w1c_bits;

    assign word    = rif_addr[4:2];
    assign decoded = (rif_addr[ADDR_WIDTH-1:5] == '0) && (word != 3'd7);

`ifdef RIF_REGFILE_LOCK_EN
    logic lock_q, lock_d;
    logic locked_wr;

    // Locked config writes miss so the adapter answers with an error response.
    assign locked_wr = lock_q && rif_wr_req
                       && (word == RegCtrl || word == RegMask || word == RegLoad);
    assign hit       = decoded && !locked_wr;
    assign lock_d    = lock_q | (wr_ctrl & ctrl_new[31]);
`else
    assign hit = decoded;
`endif

    assign rif_addr_valid = hit;

    assign wr_scr    = rif_wr_req && hit && (word == RegScr);
    assign wr_ctrl   = rif_wr_req && hit && (word == RegCtrl);
    assign wr_status = rif_wr_req && hit && (word == RegStatus);
    assign wr_mask   = rif_wr_req && hit && (word == RegMask);
    assign wr_load   = rif_wr_req && hit && (word == RegLoad);

    always_comb begin
        ctrl_rd                       = '0;
        ctrl_rd[0]                    = en_q;
        ctrl_rd[1]                    = ar_q;
`ifdef RIF_REGFILE_LOCK_EN
        ctrl_rd[31]                   = lock_q;
`endif
        status_rd                     = '0;
        status_rd[IRQ_NUM:0]          = status_q;
        mask_rd                       = '0;
        mask_rd[IRQ_NUM:0]            = mask_q;
        load_rd                       = '0;
        load_rd[TIMER_WIDTH-1:0]      = load_q;
        value_rd                      = '0;
        value_rd[TIMER_WIDTH-1:0]     = value_q;
    end

    assign ctrl_new = byte_merge(ctrl_rd, rif_wdata, rif_wstrb);
    assign mask_new = byte_merge(mask_rd, rif_wdata, rif_wstrb);
    assign load_new = byte_merge(load_rd, rif_wdata, rif_wstrb);
    assign w1c_bits = byte_merge(32'h0, rif_wdata, rif_wstrb);

    always_comb begin
        rif_rdata = '0;
        if (hit) begin
            case (word)
                RegId:     rif_rdata = ID_VALUE;
                RegScr:    rif_rdata = scratch_q;
                RegCtrl:   rif_rdata = ctrl_rd;
                RegStatus: rif_rdata = status_rd;
                RegMask:   rif_rdata = mask_rd;
                RegLoad:   rif_rdata = load_rd;
                RegValue:  rif_rdata = value_rd;
                default:   rif_rdata = '0;
            endcase
        end
    end

    assign expire = en_q && (value_q == '0);

    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        value_d   = value_q;
        scratch_d = wr_scr ? byte_merge(scratch_q, rif_wdata, rif_wstrb) : scratch_q;
        mask_d    = wr_mask ? mask_new[IRQ_NUM:0] : mask_q;
        load_d    = wr_load ? load_new[TIMER_WIDTH-1:0] : load_q;

        if (wr_ctrl && !en_q && ctrl_new[0]) begin
            value_d = load_q;
        end else if (expire) begin
            if (ar_q) value_d = load_q;
            else      en_d    = 1'b0;
        end else if (en_q) begin
            value_d = value_q - TIMER_WIDTH'(1);
        end else if (wr_load) begin
            value_d = load_new[TIMER_WIDTH-1:0];
        end
        // A CTRL write overrides the one-shot hardware EN clear.
        if (wr_ctrl) begin
            en_d = ctrl_new[0];
            ar_d = ctrl_new[1];
        end

        // Set events are applied after the clear so a coincident edge keeps the bit.
        status_d = status_q & ~(wr_status ? w1c_bits[IRQ_NUM:0] : '0);
        status_d = status_d | {irq_src & ~irq_src_q, expire};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            scratch_q <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            status_q  <= '0;
            mask_q    <= '0;
            load_q    <= '0;
            value_q   <= '0;
            irq_src_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            load_q    <= load_d;
            value_q   <= value_d;
            irq_src_q <= irq_src;
            irq_q     <= |(status_q & mask_q);
        end
    end

`ifdef RIF_REGFILE_LOCK_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`endif

    assign irq = irq_q;

    logic unused_bits;
    assign unused_bits = ^{rif_addr[1:0], rif_rd_req, ctrl_new, mask_new, load_new, w1c_bits};

endmodule

// File: tb/tb_rif_regfile.sv
// tb_rif_regfile: directed plus randomized checks of rif_regfile against a behavioural model.
module tb_rif_regfile;

    localparam int unsigned IRQ_NUM  = 7;
    localparam logic [31:0] ID_VALUE = 32'hA11C_0001;
    localparam logic [31:0] STS_MASK = 32'h0000_00FF;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [11:0]        rif_addr;
    logic               rif_addr_valid;
    logic               rif_wr_req;
    logic               rif_rd_req;
    logic [3:0]         rif_wstrb;
    logic [31:0]        rif_wdata;
    logic [31:0]        rif_rdata;
    logic [IRQ_NUM-1:0] irq_src;
    logic               irq;

    rif_regfile dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .rif_addr       (rif_addr),
        .rif_addr_valid (rif_addr_valid),
        .rif_wr_req     (rif_wr_req),
        .rif_rd_req     (rif_rd_req),
        .rif_wstrb      (rif_wstrb),
        .rif_wdata      (rif_wdata),
        .rif_rdata      (rif_rdata),
        .irq_src        (irq_src),
        .irq            (irq)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0]        m_scratch, m_status, m_mask, m_load, m_value;
    logic               m_en, m_ar, m_lock, m_irq;
    logic [IRQ_NUM-1:0] m_src_prev;

    logic [31:0] last_rdata;
    logic        last_valid;
    logic [IRQ_NUM-1:0] src;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic [11:0] a, input logic wr);
        int w;
        w = int'(a) / 4;
        if (a >= 12'h01C) return 1'b0;
        if (m_lock && wr && (w == 2 || w == 4 || w == 5)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_ctrl();
        return {m_lock, 29'b0, m_ar, m_en};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, input logic wr);
        if (!m_hit(a, wr)) return 32'h0;
        case (int'(a) / 4)
            0:       return ID_VALUE;
            1:       return m_scratch;
            2:       return m_ctrl();
            3:       return m_status;
            4:       return m_mask;
            5:       return m_load;
            6:       return m_value;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_scratch = 0; m_status = 0; m_mask = 0; m_load = 0; m_value = 0;
        m_en = 0; m_ar = 0; m_lock = 0; m_irq = 0; m_src_prev = '0;
    endtask

    // Applies one clock edge of the specification's rules to the model.
    task automatic model_clock();
        int          w;
        logic        wr;
        logic        expire;
        logic [31:0] cn, clr, set;
        logic [31:0] n_value, n_status, n_mask, n_load;
        logic        n_en, n_ar, n_lock;
        w      = int'(rif_addr) / 4;
        wr     = rif_wr_req && m_hit(rif_addr, rif_wr_req);
        cn     = merge(m_ctrl(), rif_wdata, rif_wstrb);
        expire = m_en && (m_value == 0);
        n_value = m_value; n_en = m_en; n_ar = m_ar; n_lock = m_lock;
        n_mask  = (wr && w == 4) ? (merge(m_mask, rif_wdata, rif_wstrb) & STS_MASK) : m_mask;
        n_load  = (wr && w == 5) ? merge(m_load, rif_wdata, rif_wstrb) : m_load;
        if (wr && w == 1) m_scratch = merge(m_scratch, rif_wdata, rif_wstrb);
        if (wr && w == 2 && !m_en && cn[0]) n_value = m_load;
        else if (expire) begin
            if (m_ar) n_value = m_load;
            else      n_en = 0;
        end else if (m_en) n_value = m_value - 1;
        else if (wr && w == 5) n_value = n_load;
        if (wr && w == 2) begin
            n_en = cn[0];
            n_ar = cn[1];
`ifdef RIF_REGFILE_LOCK_EN
            n_lock = m_lock | cn[31];
`endif
        end
        clr = (wr && w == 3) ? merge(32'h0, rif_wdata, rif_wstrb) : 32'h0;
        set = (32'(irq_src & ~m_src_prev) << 1) | 32'(expire);
        n_status = ((m_status & ~clr) | set) & STS_MASK;
        m_irq      = |(m_status & m_mask);
        m_status   = n_status; m_mask = n_mask; m_load = n_load; m_value = n_value;
        m_en       = n_en; m_ar = n_ar; m_lock = n_lock;
        m_src_prev = irq_src;
    endtask

    // One bus cycle: drive at negedge, check comb outputs, clock, then check irq.
    task automatic step(input logic wr, input logic [11:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [IRQ_NUM-1:0] s);
        rif_wr_req = wr; rif_rd_req = !wr; rif_addr = a;
        rif_wstrb = be; rif_wdata = wd; irq_src = s;
        #1;
        last_rdata = rif_rdata;
        last_valid = rif_addr_valid;
        check($sformatf("addr_valid@%h", a), 32'(rif_addr_valid), 32'(m_hit(a, wr)));
        check($sformatf("rdata@%h", a), rif_rdata, m_read(a, wr));
        @(posedge HCLK);
        model_clock();
        @(negedge HCLK);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b0, a, 4'h0, 32'h0, src);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(1'b1, a, 4'hF, d, src);
    endtask

    initial begin
        HRESET = 1'b1; rif_addr = '0; rif_wr_req = 0; rif_rd_req = 0;
        rif_wstrb = '0; rif_wdata = '0; irq_src = '0; src = '0;
        model_reset();
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        // Reset state
        check("irq_reset", 32'(irq), 32'h0);
        for (int a = 0; a <= 'h18; a += 4) rd(12'(a));
        rd(12'h000);
        check("id_const", last_rdata, ID_VALUE);

        // Unmapped addresses
        rd(12'h01C);
        check("miss_1c_valid", 32'(last_valid), 32'h0);
        rd(12'h400);
        check("miss_400_rdata", last_rdata, 32'h0);
        wr(12'h01C, 32'hFFFF_FFFF);
        for (int a = 0; a <= 'h18; a += 4) rd(12'(a));

        // Byte-strobed scratch write
        wr(12'h004, 32'h0);
        step(1'b1, 12'h004, 4'b0101, 32'hDEAD_BEEF, src);
        rd(12'h004);
        check("scratch_strb", last_rdata, 32'h00AD_00EF);

        // One-shot timer
        wr(12'h014, 32'd3);
        wr(12'h008, 32'h1);
        for (int i = 3; i >= 0; i--) begin
            rd(12'h018);
            check("timer_count", last_rdata, 32'(i));
        end
        rd(12'h00C);
        check("timer_expire", last_rdata, 32'h1);
        rd(12'h008);
        check("timer_en_clr", last_rdata, 32'h0);
        wr(12'h00C, 32'h1);

        // Auto-reload timer
        wr(12'h008, 32'h3);
        for (int i = 0; i < 12; i++) begin
            rd(12'h00C);
            if (last_rdata[0]) wr(12'h00C, 32'h1);
        end
        wr(12'h008, 32'h0);
        wr(12'h00C, 32'hFF);

        // Edge-captured interrupt with mask
        wr(12'h010, 32'h4);
        src = 7'b000_0010; rd(12'h00C);
        src = 7'b000_0000; rd(12'h00C);
        check("irq_status", last_rdata, 32'h4);
        check("irq_set", 32'(irq), 32'h1);
        src = 7'b000_0010; wr(12'h00C, 32'h4);
        src = 7'b000_0000; rd(12'h00C);
        check("w1c_set_wins", last_rdata, 32'h4);
        wr(12'h00C, 32'h4);
        rd(12'h00C);
        check("irq_cleared", 32'(irq), 32'h0);

        // Timer running, optional lock, then asynchronous reset mid-count
        wr(12'h014, 32'd100);
        wr(12'h008, 32'h1);
`ifdef RIF_REGFILE_LOCK_EN
        wr(12'h008, 32'h8000_0001);
        wr(12'h010, 32'hFF);
        check("lock_wr_invalid", 32'(last_valid), 32'h0);
        rd(12'h010);
        check("lock_mask_kept", last_rdata, 32'h4);
`endif
        repeat (3) rd(12'h018);
        HRESET = 1'b1;
        rif_wr_req = 0; rif_addr = 12'h018;
        #1;
        check("rst_async_value", rif_rdata, 32'h0);
        check("rst_async_irq", 32'(irq), 32'h0);
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
        src = '0;
        rd(12'h018);
        rd(12'h008);
        check("rst_ctrl", last_rdata, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic [31:0] d;
            logic        w;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 12'($urandom_range(0, 31));
            else if (sel == 8) a = 12'h400 | 12'($urandom_range(0, 31));
            else               a = 12'($urandom);
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            if (a[11:2] == 10'd5 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 7));
            if (a[11:2] == 10'd2 && $urandom_range(0, 7) != 0) d = d & 32'h3;
            src = src ^ (IRQ_NUM'($urandom) & IRQ_NUM'($urandom) & IRQ_NUM'($urandom));
            step(w, a, 4'($urandom), d, src);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
